// File: rtl/addsub_pkg.sv
// addsub_pkg: shared control struct and saturation constants for pipelined_addsub
package addsub_pkg;
  typedef struct packed {
    logic valid;
    logic sub;
    logic sat;
    logic carry;
  } ctl_t;
  function automatic logic [63:0] sat_val(input int width, input logic pos);
    logic [63:0] min_v;
    min_v = 64'd1 << (width - 1);
    return pos ? min_v - 64'd1 : min_v;
  endfunction
endpackage

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle for pipelined_addsub
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             i_sub;
  logic             i_sat;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_ovf;
  modport master (
    output i_valid, i_a, i_b, i_cin, i_sub, i_sat, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_ovf
  );
  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_sub, i_sat, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_ovf
  );
endinterface

// File: rtl/addsub_seg.sv
// addsub_seg: combinational ripple segment reporting carry-out and carry into its MSB
module addsub_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
  assign cmsb = a[W-1] ^ b[W-1] ^ sum[W-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: segmented-carry add/sub with optional saturation behind a valid/ready pipeline
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input logic i_clk,
  input logic i_rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / SEG_WIDTH;
  logic             en;
  logic             ovf;
  logic             cmsb_q;
  logic [WIDTH-1:0] r_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] r_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  ctl_t             c_in [STAGES];
  ctl_t             c_q  [STAGES];
  if (WIDTH % SEG_WIDTH != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of SEG_WIDTH");
  end
  assign en          = ~c_q[STAGES-1].valid | bus.i_ready;
  assign bus.o_ready = en;
  // r carries resolved sum segments below stage k and untouched A segments above it
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LSB = k * SEG_WIDTH;
    logic [SEG_WIDTH-1:0] sum;
    logic                 cout;
    logic                 cmsb;
    if (k == 0) begin : g_head
      assign r_in[k] = bus.i_a;
      assign b_in[k] = bus.i_sub ? ~bus.i_b : bus.i_b;
      assign c_in[k] = '{valid: bus.i_valid, sub: bus.i_sub, sat: bus.i_sat,
                         carry: bus.i_sub ^ bus.i_cin};
    end else begin : g_tail
      assign r_in[k] = r_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
    end
    addsub_seg #(.W(SEG_WIDTH)) u_seg (
      .a   (r_in[k][LSB +: SEG_WIDTH]),
      .b   (b_in[k][LSB +: SEG_WIDTH]),
      .cin (c_in[k].carry),
      .sum (sum),
      .cout(cout),
      .cmsb(cmsb)
    );
    always_ff @(posedge i_clk)
      if (!i_rst_n) begin
        r_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= '0;
      end else if (en) begin
        r_q[k]                   <= r_in[k];
        r_q[k][LSB +: SEG_WIDTH] <= sum;
        b_q[k]                   <= b_in[k];
        c_q[k] <= '{valid: c_in[k].valid, sub: c_in[k].sub, sat: c_in[k].sat, carry: cout};
      end
    if (k == STAGES - 1) begin : g_msb
      always_ff @(posedge i_clk)
        if (!i_rst_n) cmsb_q <= 1'b0;
        else if (en) cmsb_q <= cmsb;
    end
  end
  assign ovf         = cmsb_q ^ c_q[STAGES-1].carry;
  assign bus.o_valid = c_q[STAGES-1].valid;
  assign bus.o_carry = c_q[STAGES-1].carry;
  assign bus.o_ovf   = ovf;
  assign bus.o_sum   = (c_q[STAGES-1].sat & ovf) ? WIDTH'(sat_val(WIDTH, cmsb_q)) : r_q[STAGES-1];
endmodule
